// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port burst arbiter.
// Holds the arbiter state encoding, the FIFO capacity helper and the
// admission margin used when deciding whether a whole burst will fit.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } arbState_e;

  // Capacity of the default 2^8-entry write FIFO; modules with a different
  // depth derive their own capacity through fifoCap().
  localparam int DEPTH_WIDTH_DEFAULT = 8;
  localparam int FIFO_CAP            = 1 << DEPTH_WIDTH_DEFAULT;

  // Extra free words demanded beyond one burst: the water level reported by
  // the FIFO may trail the real fill by a cycle.
  localparam int ADMIT_MARGIN = 2;

  function automatic int fifoCap(input int depthWidth);
    return 1 << depthWidth;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port signal bundle for fifo_wr_arbiter.
// The master modport is the arbiter's view; slave is the environment's view
// (requesters plus the FIFO write side).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8
);

  logic [NUM_REQ-1:0]            src_req;
  logic [NUM_REQ-1:0]            src_valid;
  logic [NUM_REQ-1:0]            src_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] src_data;
  logic [NUM_REQ-1:0]            src_ready;
  logic [NUM_REQ-1:0]            src_gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_wr_full;
  logic [DEPTH_WIDTH:0]          fifo_wr_level;
  logic                          busy;

  modport master (
    input  src_req, src_valid, src_last, src_data, fifo_wr_full, fifo_wr_level,
    output src_ready, src_gnt, fifo_wr_en, fifo_wr_data, busy
  );

  modport slave (
    output src_req, src_valid, src_last, src_data, fifo_wr_full, fifo_wr_level,
    input  src_ready, src_gnt, fifo_wr_en, fifo_wr_data, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Returns a one-hot grant for
// the first set bit of req, searching upward from ptr and wrapping modulo N.
// Contains no state, so any arbiter can reuse it with its own pointer.
module rr_pick #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  int   idx;
  logic found;

  // Walk the requesters in priority order starting at ptr; first hit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port.
// A requester is granted a whole burst only when the FIFO water level shows
// room for BURST_LEN words plus a lag margin; bursts never interleave.
// Optional macro FIFO_WR_ARB_STATS_EN adds per-requester word counters and a
// stall-cycle counter (stat_words, stat_stall).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 8,
  parameter int BURST_LEN   = 16
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  fifo_wr_arbiter_if.master    bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_words,
  output logic [31:0]           stat_stall
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int ADMIT = BURST_LEN + ADMIT_MARGIN;
  localparam logic [DEPTH_WIDTH:0] CAP_V = (DEPTH_WIDTH + 1)'(fifoCap(DEPTH_WIDTH));

  arbState_e          state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [PTR_W-1:0]   rrPtr_q;
  logic [PTR_W-1:0]   rrPtr_d;
  logic [CNT_W-1:0]   beatCnt_q;
  logic               busy_q;

  logic [DEPTH_WIDTH:0] freeWords;
  logic                 admit;
  logic [NUM_REQ-1:0]   pickGnt;
  logic [PTR_W-1:0]     gIdx;
  logic                 accept;
  logic                 lastBeat;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (bus.src_req),
    .ptr (rrPtr_q),
    .gnt (pickGnt)
  );

  assign freeWords = CAP_V - bus.fifo_wr_level;
  assign admit     = (32'(freeWords) >= 32'(ADMIT));

  // Turn the registered one-hot grant into an index for slicing and pointer update.
  always_comb begin
    gIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) gIdx = PTR_W'(i);
    end
  end

  assign rrPtr_d  = (gIdx == PTR_W'(NUM_REQ - 1)) ? '0 : gIdx + 1'b1;
  assign accept   = bus.fifo_wr_en;
  assign lastBeat = (beatCnt_q == CNT_W'(BURST_LEN - 1)) || bus.src_last[gIdx];

  assign bus.src_gnt      = gnt_q;
  assign bus.src_ready    = gnt_q & {NUM_REQ{~bus.fifo_wr_full}};
  assign bus.fifo_wr_en   = (|(gnt_q & bus.src_valid)) & ~bus.fifo_wr_full;
  assign bus.fifo_wr_data = bus.src_data[int'(gIdx)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.busy         = busy_q;

  // Arbiter FSM: admit a burst from IDLE, count accepted beats, rest one GAP cycle.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      rrPtr_q   <= '0;
      beatCnt_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((|bus.src_req) && admit) begin
            gnt_q     <= pickGnt;
            beatCnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (lastBeat) begin
              gnt_q     <= '0;
              rrPtr_q   <= rrPtr_d;
              beatCnt_q <= '0;
              state_q   <= GAP;
            end else begin
              beatCnt_q <= beatCnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] statWords_q [NUM_REQ];
  logic [31:0] statStall_q;

  // Free-running statistics: accepted beats per requester and full-stalled cycles.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      for (int i = 0; i < NUM_REQ; i++) statWords_q[i] <= '0;
      statStall_q <= '0;
    end else begin
      if (accept) statWords_q[gIdx] <= statWords_q[gIdx] + 32'd1;
      if ((state_q == BURST) && (|(gnt_q & bus.src_valid)) && bus.fifo_wr_full)
        statStall_q <= statStall_q + 32'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
    assign stat_words[gi*32 +: 32] = statWords_q[gi];
  end
  assign stat_stall = statStall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_WIDTH  = 8;
  localparam int DEPTH_WIDTH = 8;
  localparam int BURST_LEN   = 16;
  localparam int CAP         = 256;

  logic wr_clk = 1'b0;
  logic wr_rst;

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DEPTH_WIDTH(DEPTH_WIDTH)
  ) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] statWords;
  logic [31:0]           statStall;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_WIDTH(DEPTH_WIDTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_words (statWords),
    .stat_stall (statStall)
`endif
  );

  int totalChecks = 0;
  int badChecks   = 0;

  // Reference model: who owns the port, words written, next start point, rest cycle.
  int mOwner;
  int mWords;
  int mPtr;
  bit mGap;

  int obsLog[$];
  bit prevGntSeen;
  int wrCount;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int oneHotIndex(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mOwner = -1;
    mWords = 0;
    mPtr   = 0;
    mGap   = 1'b0;
  endtask

  // One clock of stimulus: drive after the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] valid,
                               input logic [3:0] last, input logic full,
                               input logic [8:0] level);
    logic [31:0] data;
    logic [3:0]  expGnt;
    logic [3:0]  expReady;
    logic        expEn;
    logic        expBusy;
    int          freeWords;
    bit          found;
    @(negedge wr_clk);
    data = $urandom;
    bus.src_req       = req;
    bus.src_valid     = valid;
    bus.src_last      = last;
    bus.src_data      = data;
    bus.fifo_wr_full  = full;
    bus.fifo_wr_level = level;
    #1;
    expGnt   = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0;
    expReady = (mOwner >= 0 && !full) ? expGnt : 4'b0;
    expEn    = (mOwner >= 0) && valid[mOwner] && !full;
    expBusy  = (mOwner >= 0) || mGap;
    checkOutput("src_gnt", bus.src_gnt, expGnt);
    checkOutput("src_ready", bus.src_ready, expReady);
    checkOutput("fifo_wr_en", bus.fifo_wr_en, expEn);
    checkOutput("busy", bus.busy, expBusy);
    if (expEn) checkOutput("fifo_wr_data", bus.fifo_wr_data, data[mOwner*8 +: 8]);
    if (bus.src_gnt != 0 && !prevGntSeen) obsLog.push_back(oneHotIndex(bus.src_gnt));
    prevGntSeen = (bus.src_gnt != 0);
    if (bus.fifo_wr_en) wrCount++;
    if (mOwner >= 0) begin
      if (valid[mOwner] && !full) begin
        mWords++;
        if (mWords == BURST_LEN || last[mOwner]) begin
          mPtr   = (mOwner + 1) % NUM_REQ;
          mOwner = -1;
          mGap   = 1'b1;
        end
      end
    end else if (mGap) begin
      mGap = 1'b0;
    end else begin
      freeWords = CAP - int'(level);
      found = 1'b0;
      if (req != 0 && freeWords >= BURST_LEN + 2) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && req[(mPtr + k) % NUM_REQ]) begin
            mOwner = (mPtr + k) % NUM_REQ;
            mWords = 0;
            found  = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic doReset();
    @(negedge wr_clk);
    wr_rst            = 1'b1;
    bus.src_req       = '0;
    bus.src_valid     = '0;
    bus.src_last      = '0;
    bus.src_data      = '0;
    bus.fifo_wr_full  = 1'b0;
    bus.fifo_wr_level = '0;
    @(negedge wr_clk);
    #1;
    checkOutput("rst_gnt", bus.src_gnt, 0);
    checkOutput("rst_wr_en", bus.fifo_wr_en, 0);
    checkOutput("rst_busy", bus.busy, 0);
    wr_rst = 1'b0;
    modelReset();
    prevGntSeen = 1'b0;
    obsLog.delete();
    wrCount = 0;
  endtask

  initial begin
    wr_rst            = 1'b1;
    bus.src_req       = '0;
    bus.src_valid     = '0;
    bus.src_last      = '0;
    bus.src_data      = '0;
    bus.fifo_wr_full  = 1'b0;
    bus.fifo_wr_level = '0;
    modelReset();

    // Single requester, full-length burst then idle.
    doReset();
    applyStimulus(4'b0001, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 19; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t1_beats", wrCount, 16);
    checkOutput("t1_busy_end", bus.busy, 0);

    // All requesters continuously: strict rotation 0,1,2,3,0.
    doReset();
    for (int i = 0; i < 80; i++) applyStimulus(4'b1111, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t2_nbursts", obsLog.size() >= 5, 1);
    if (obsLog.size() >= 5) begin
      checkOutput("t2_order0", obsLog[0], 0);
      checkOutput("t2_order1", obsLog[1], 1);
      checkOutput("t2_order2", obsLog[2], 2);
      checkOutput("t2_order3", obsLog[3], 3);
      checkOutput("t2_order4", obsLog[4], 0);
    end

    // Water-level admission boundary: 239 blocks, 238 admits.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(4'b0100, 4'b0000, 4'b0, 1'b0, 9'd239);
    applyStimulus(4'b0100, 4'b0000, 4'b0, 1'b0, 9'd238);
    checkOutput("t3_no_grant", bus.src_gnt, 0);
    applyStimulus(4'b0100, 4'b0000, 4'b0, 1'b0, 9'd238);
    checkOutput("t3_grant2", bus.src_gnt, 4'b0100);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd238);

    // FIFO full for three cycles after beat 5: no beat lost or duplicated.
    doReset();
    applyStimulus(4'b0001, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b1, 9'd0);
    for (int i = 0; i < 16; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t4_beats", wrCount, 16);

    // Short burst ended by last on beat 4; pointer then favours requester 2.
    doReset();
    applyStimulus(4'b0010, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    applyStimulus(4'b0000, 4'b1111, 4'b0010, 1'b0, 9'd0);
    applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t5_beats", wrCount, 4);
    applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t5_next_owner", obsLog.size() >= 2 ? obsLog[1] : -1, 2);
    for (int i = 0; i < 20; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);

    // Asynchronous reset mid-burst at beat 7, then arbitration restarts at 0.
    doReset();
    applyStimulus(4'b0001, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 18; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    applyStimulus(4'b0100, 4'b1111, 4'b0, 1'b0, 9'd0);
    for (int i = 0; i < 7; i++) applyStimulus(4'b0000, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t6_in_burst", bus.src_gnt, 4'b0100);
    @(negedge wr_clk);
    #2;
    wr_rst = 1'b1;
    #1;
    checkOutput("t6_async_gnt", bus.src_gnt, 0);
    checkOutput("t6_async_wr_en", bus.fifo_wr_en, 0);
    checkOutput("t6_async_busy", bus.busy, 0);
    @(negedge wr_clk);
    #1;
    wr_rst = 1'b0;
    modelReset();
    prevGntSeen = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 4'b1111, 4'b0, 1'b0, 9'd0);
    checkOutput("t6_restart", obsLog.size() >= 3 ? obsLog[2] : -1, 0);

    // Random traffic against the model.
    doReset();
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] rReq;
      logic [3:0] rValid;
      logic [3:0] rLast;
      logic       rFull;
      logic [8:0] rLevel;
      rReq   = 4'($urandom);
      rValid = 4'($urandom) | 4'($urandom);
      rLast  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      rFull  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       rLevel = 9'd0;
        1:       rLevel = 9'd238;
        2:       rLevel = 9'd239;
        default: rLevel = 9'($urandom_range(0, 256));
      endcase
      applyStimulus(rReq, rValid, rLast, rFull, rLevel);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
